// File: rtl/alu_pkg.sv
// Shared types and constants for the digit-serial ALU.
package alu_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_ADJ = 4'd6;

    // Nine operations do not fit in three bits, so the opcode is four bits wide.
    // Codes 9..15 are reserved and produce the illegal-op result.
    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_EOR = 4'd3,
        OP_OR  = 4'd4,
        OP_ASL = 4'd5,
        OP_LSR = 4'd6,
        OP_ROL = 4'd7,
        OP_ROR = 4'd8
    } alu_op_t;

    typedef struct packed {
        logic c;
        logic h;
        logic v;
        logic z;
        logic n;
    } alu_flags_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    function automatic logic is_arith(input alu_op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One 4-bit digit of the serial adder, with optional BCD adjust and subtract.
module bcd_digit_adder
    import alu_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    input  logic               decimal,
    input  logic               sub,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout,
    output logic               bin_cout
);

    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W:0]   raw;

    // Binary digit sum, then decimal correction; subtract adds the inverted digit.
    always_comb begin
        b_eff    = sub ? ~b : b;
        raw      = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
        bin_cout = raw[DIGIT_W];
        sum      = raw[DIGIT_W-1:0];
        cout     = raw[DIGIT_W];
        if (decimal) begin
            if (!sub) begin
                if (raw > (DIGIT_W+1)'(9)) begin
                    sum  = raw[DIGIT_W-1:0] + BCD_ADJ;
                    cout = 1'b1;
                end else begin
                    cout = 1'b0;
                end
            end else if (!raw[DIGIT_W]) begin
                sum = raw[DIGIT_W-1:0] - BCD_ADJ;
            end
        end
    end

endmodule

// File: rtl/digit_serial_alu.sv
// Digit-serial ALU: ADD/SUB one digit per cycle LSB first, logic and shifts in one cycle.
//
//   state   | meaning
//   IDLE    | waiting for a request, in_ready high
//   RUN     | processing digits (arith) or the single full-width step
//   DONE    | result and flags presented, held until out_ready
module digit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    input  logic             decimal_enable,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             carry,
    output logic             half_carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int CNT_W = $clog2(NDIG);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NDIG - 1);

    alu_state_t         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    alu_op_t            op_q, op_d;
    logic               c_q, c_d, bc_q, bc_d, dec_q, dec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    alu_flags_t         flags_q, flags_d;

    logic               accept, arith, sub, last_step;
    logic [DIGIT_W-1:0] dig_sum, b_dig_eff;
    logic               dig_cout, dig_bcout, dig_carry;
    logic               bc_next, c_into_msb, v_top;

    assign arith     = is_arith(op_q);
    assign sub       = (op_q == OP_SUB);
    assign accept    = in_valid && in_ready;
    assign last_step = (state_q == ST_RUN) && (!arith || (cnt_q == '0));

    bcd_digit_adder u_digit (
        .a        (a_q[DIGIT_W-1:0]),
        .b        (b_q[DIGIT_W-1:0]),
        .cin      (c_q),
        .decimal  (dec_q),
        .sub      (sub),
        .sum      (dig_sum),
        .cout     (dig_cout),
        .bin_cout (dig_bcout)
    );

    // Overflow always follows the binary sum, so a binary carry chain runs beside the decimal one.
    always_comb begin
        dig_carry  = dec_q ? dig_cout : dig_bcout;
        b_dig_eff  = sub ? ~b_q[DIGIT_W-1:0] : b_q[DIGIT_W-1:0];
        bc_next    = ({1'b0, a_q[DIGIT_W-1:0]} + {1'b0, b_dig_eff}
                      + {{DIGIT_W{1'b0}}, bc_q}) > (DIGIT_W+1)'(15);
        c_into_msb = ({1'b0, a_q[DIGIT_W-2:0]} + {1'b0, b_dig_eff[DIGIT_W-2:0]}
                      + {{(DIGIT_W-1){1'b0}}, bc_q}) > DIGIT_W'(7);
        v_top      = (a_q[DIGIT_W-1] == b_dig_eff[DIGIT_W-1]) && (c_into_msb != a_q[DIGIT_W-1]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; DONE can go straight back to RUN when a new request is accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (last_step) state_d = ST_DONE;
            ST_DONE: begin
                if (accept)         state_d = ST_RUN;
                else if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        out_valid = (state_q == ST_DONE);
    end

    // Datapath: latch on accept, shift one digit per RUN cycle, hold otherwise.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        c_d     = c_q;
        bc_d    = bc_q;
        dec_d   = dec_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        flags_d = flags_q;
        if (accept) begin
            a_d     = a_in;
            b_d     = b_in;
            op_d    = alu_op_t'(op);
            c_d     = carry_in;
            bc_d    = carry_in;
            dec_d   = decimal_enable & DECIMAL_EN;
            cnt_d   = CNT_LOAD;
            flags_d = '0;
        end else if (state_q == ST_RUN) begin
            if (arith) begin
                a_d   = a_q >> DIGIT_W;
                b_d   = b_q >> DIGIT_W;
                c_d   = dig_carry;
                bc_d  = bc_next;
                res_d = {dig_sum, res_q[WIDTH-1:DIGIT_W]};
                if (cnt_q == CNT_LOAD) flags_d.h = dig_carry;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    flags_d.c = dig_carry;
                    flags_d.v = v_top;
                    flags_d.z = (res_d == '0);
                    flags_d.n = res_d[WIDTH-1];
                end
            end else begin
                unique case (op_q)
                    OP_AND: res_d = a_q & b_q;
                    OP_EOR: res_d = a_q ^ b_q;
                    OP_OR:  res_d = a_q | b_q;
                    OP_ASL: begin res_d = {a_q[WIDTH-2:0], 1'b0};  flags_d.c = a_q[WIDTH-1]; end
                    OP_ROL: begin res_d = {a_q[WIDTH-2:0], c_q};   flags_d.c = a_q[WIDTH-1]; end
                    OP_LSR: begin res_d = {1'b0, a_q[WIDTH-1:1]};  flags_d.c = a_q[0]; end
                    OP_ROR: begin res_d = {c_q, a_q[WIDTH-1:1]};   flags_d.c = a_q[0]; end
                    default: res_d = '1;
                endcase
                // All-ones illegal result naturally gives zero=0, negative=1.
                flags_d.z = (res_d == '0);
                flags_d.n = res_d[WIDTH-1];
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            c_q     <= 1'b0;
            bc_q    <= 1'b0;
            dec_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            c_q     <= c_d;
            bc_q    <= bc_d;
            dec_q   <= dec_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign data_out   = res_q;
    assign carry      = flags_q.c;
    assign half_carry = flags_q.h;
    assign overflow   = flags_q.v;
    assign zero       = flags_q.z;
    assign negative   = flags_q.n;

endmodule

// File: tb/tb_digit_serial_alu.sv
// Scoreboard bench for digit_serial_alu: 8-bit and 16-bit instances side by side.
module tb_digit_serial_alu;
    import alu_pkg::*;

    typedef struct {
        logic [15:0] d;
        logic [4:0]  f;   // {c,h,v,z,n}
        int          lat;
        int          acc;
    } exp_t;

    logic clk;
    int   cyc = 0;
    int   checks = 0;
    int   errs = 0;

    logic       rst8_n, in_valid8, in_ready8, cin8, dec8, out_valid8, out_ready8;
    logic [3:0] op8;
    logic [7:0] a8, b8, d8;
    logic       c8, h8, v8, z8, n8;

    logic        rst16_n, in_valid16, in_ready16, cin16, dec16, out_valid16, out_ready16;
    logic [3:0]  op16;
    logic [15:0] a16, b16, d16;
    logic        c16, h16, v16, z16, n16;

    bit hold8 = 0, hold16 = 0, rnd8 = 0, rnd16 = 0;

    exp_t q8[$];
    exp_t q16[$];
    exp_t cur[2];
    bit   seen[2];

    digit_serial_alu #(.WIDTH(8), .DECIMAL_EN(1'b1)) u_dut8 (
        .clk(clk), .rst_n(rst8_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
        .a_in(a8), .b_in(b8), .carry_in(cin8), .decimal_enable(dec8),
        .out_valid(out_valid8), .out_ready(out_ready8), .data_out(d8),
        .carry(c8), .half_carry(h8), .overflow(v8), .zero(z8), .negative(n8)
    );

    digit_serial_alu #(.WIDTH(16), .DECIMAL_EN(1'b1)) u_dut16 (
        .clk(clk), .rst_n(rst16_n), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
        .a_in(a16), .b_in(b16), .carry_in(cin16), .decimal_enable(dec16),
        .out_valid(out_valid16), .out_ready(out_ready16), .data_out(d16),
        .carry(c16), .half_carry(h16), .overflow(v16), .zero(z16), .negative(n16)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: whole-operand arithmetic plus the per-digit BCD rules.
    function automatic exp_t model(input int w, input int op, input int a_i, input int b_i,
                                   input bit c, input bit dec);
        exp_t e;
        int mask, sm, a, b, bb, full, r, cy, s, da, db;
        bit co, h, v, z, n;
        mask = (1 << w) - 1; sm = 1 << (w - 1);
        a = a_i & mask; b = b_i & mask;
        r = 0; co = 0; h = 0; v = 0;
        e.lat = 1;
        case (op)
            0, 1: begin
                bb   = (op == 1) ? (~b & mask) : b;
                full = a + bb + int'(c);
                v    = ((a & sm) == (bb & sm)) && ((full & sm) != (a & sm));
                if (dec) begin
                    cy = int'(c);
                    for (int i = 0; i < w / 4; i++) begin
                        da = (a >> (4 * i)) & 15;
                        db = (bb >> (4 * i)) & 15;
                        s  = da + db + cy;
                        if (op == 0) begin
                            if (s > 9) begin s = s + 6; cy = 1; end
                            else cy = 0;
                        end else begin
                            cy = (s > 15) ? 1 : 0;
                            if (cy == 0) s = s - 6;
                        end
                        r = r | ((s & 15) << (4 * i));
                        if (i == 0) h = (cy != 0);
                    end
                    co = (cy != 0);
                end else begin
                    r  = full & mask;
                    co = ((full >> w) & 1) != 0;
                    h  = ((a & 15) + (bb & 15) + int'(c)) > 15;
                end
                e.lat = w / 4;
            end
            2: r = a & b;
            3: r = a ^ b;
            4: r = a | b;
            5: begin r = (a << 1) & mask;               co = ((a >> (w - 1)) & 1) != 0; end
            7: begin r = ((a << 1) & mask) | int'(c);   co = ((a >> (w - 1)) & 1) != 0; end
            6: begin r = a >> 1;                        co = (a & 1) != 0; end
            8: begin r = (a >> 1) | (int'(c) << (w - 1)); co = (a & 1) != 0; end
            default: r = mask;
        endcase
        z = (r == 0);
        n = (r & sm) != 0;
        e.d = 16'(r);
        e.f = {co, h, v, z, n};
        e.acc = 0;
        return e;
    endfunction

    task automatic drive(input int which, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input bit c, input bit dec, input bit v);
        if (which == 0) begin
            op8 = op; a8 = a[7:0]; b8 = b[7:0]; cin8 = c; dec8 = dec; in_valid8 = v;
        end else begin
            op16 = op; a16 = a; b16 = b; cin16 = c; dec16 = dec; in_valid16 = v;
        end
    endtask

    task automatic get_out(input int which, output logic [15:0] d, output logic [4:0] f,
                           output logic ov, output logic ordy, output logic ir);
        if (which == 0) begin
            d = {8'h00, d8}; f = {c8, h8, v8, z8, n8};
            ov = out_valid8; ordy = out_ready8; ir = in_ready8;
        end else begin
            d = d16; f = {c16, h16, v16, z16, n16};
            ov = out_valid16; ordy = out_ready16; ir = in_ready16;
        end
    endtask

    // Present a request from a falling edge; push the expectation once it is accepted.
    task automatic issue_core(input int which, input logic [3:0] op, input logic [15:0] a,
                              input logic [15:0] b, input bit c, input bit dec,
                              input exp_t e_in, output bit first);
        exp_t e;
        logic [15:0] d; logic [4:0] f; logic ov, ordy, ir;
        bit acc;
        e = e_in; acc = 0; first = 0;
        @(negedge clk);
        drive(which, op, a, b, c, dec, 1'b1);
        for (int k = 0; k < 300 && !acc; k++) begin
            #1;
            get_out(which, d, f, ov, ordy, ir);
            if (ir) begin
                acc = 1; first = (k == 0); e.acc = cyc + 1;
                if (which == 0) q8.push_back(e); else q16.push_back(e);
            end else begin
                @(negedge clk);
            end
        end
        if (!acc) begin
            checks++; errs++;
            $display("FAIL accept_timeout: dut%0d never raised in_ready, expected within 300 cycles", which);
            drive(which, op, a, b, c, dec, 1'b0);
            return;
        end
        @(posedge clk);
        #1;
        drive(which, 4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic issue_m(input int which, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input bit c, input bit dec, output bit first);
        exp_t e;
        e = model(which ? 16 : 8, int'(op), int'(a), int'(b), c, dec);
        issue_core(which, op, a, b, c, dec, e, first);
    endtask

    task automatic issue_k(input int which, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input bit c, input bit dec,
                           input logic [15:0] ed, input logic [4:0] ef, input int lat);
        exp_t e;
        bit first;
        e.d = ed; e.f = ef; e.lat = lat; e.acc = 0;
        issue_core(which, op, a, b, c, dec, e, first);
    endtask

    task automatic mon(input int which);
        logic [15:0] d; logic [4:0] f; logic ov, ordy, ir;
        exp_t e;
        string p;
        int qs;
        p = which ? "w16" : "w8";
        get_out(which, d, f, ov, ordy, ir);
        if (!ov) return;
        if (!seen[which]) begin
            qs = which ? q16.size() : q8.size();
            if (qs == 0) begin
                checks++; errs++;
                $display("FAIL %s_unexpected: got result 0x%0h, expected no result", p, d);
                cur[which].d = d; cur[which].f = f;
            end else begin
                if (which == 0) e = q8.pop_front(); else e = q16.pop_front();
                cur[which] = e;
                chk({p, "_data"}, 32'(d), 32'(e.d));
                chk({p, "_flags_chvzn"}, 32'(f), 32'(e.f));
                chk({p, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
            end
            seen[which] = 1;
        end else begin
            chk({p, "_hold_data"}, 32'(d), 32'(cur[which].d));
            chk({p, "_hold_flags"}, 32'(f), 32'(cur[which].f));
        end
        if (ordy) seen[which] = 0;
    endtask

    initial begin
        seen[0] = 0; seen[1] = 0;
        forever begin
            @(negedge clk);
            #2;
            mon(0);
            mon(1);
        end
    end

    initial begin
        out_ready8 = 1; out_ready16 = 1;
        forever begin
            @(negedge clk);
            out_ready8  = hold8  ? 1'b0 : (rnd8  ? ($urandom_range(0, 3) != 0) : 1'b1);
            out_ready16 = hold16 ? 1'b0 : (rnd16 ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    task automatic drain(input int which);
        bit done;
        done = 0;
        for (int k = 0; k < 500 && !done; k++) begin
            @(negedge clk);
            #3;
            if (which == 0) done = (q8.size() == 0) && !out_valid8;
            else            done = (q16.size() == 0) && !out_valid16;
        end
        if (!done) begin
            checks++; errs++;
            $display("FAIL drain_timeout: dut%0d results outstanding, expected none", which);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit first;
        logic [15:0] ra, rb;
        logic [3:0]  rop;
        int w;
        rst8_n = 0; rst16_n = 0;
        drive(0, 4'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        drive(1, 4'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst8_n = 1; rst16_n = 1;
        @(negedge clk);
        #1;
        chk("rst_w8_in_ready", 32'(in_ready8), 1);
        chk("rst_w8_out_valid", 32'(out_valid8), 0);
        chk("rst_w8_data", 32'(d8), 0);
        chk("rst_w8_flags", 32'({c8, h8, v8, z8, n8}), 0);
        chk("rst_w16_in_ready", 32'(in_ready16), 1);
        chk("rst_w16_out_valid", 32'(out_valid16), 0);
        chk("rst_w16_data", 32'(d16), 0);
        chk("rst_w16_flags", 32'({c16, h16, v16, z16, n16}), 0);

        // Known vectors, flags as {c,h,v,z,n}.
        issue_k(0, OP_ADD, 16'h50, 16'h50, 1'b0, 1'b0, 16'hA0, 5'b00101, 2);
        issue_k(0, OP_ADD, 16'h58, 16'h46, 1'b1, 1'b1, 16'h05, 5'b11100, 2);
        issue_k(0, OP_SUB, 16'h12, 16'h21, 1'b1, 1'b1, 16'h91, 5'b01001, 2);
        issue_k(0, OP_ROR, 16'h01, 16'h00, 1'b1, 1'b0, 16'h80, 5'b10001, 1);
        issue_k(0, OP_ASL, 16'h80, 16'h00, 1'b0, 1'b0, 16'h00, 5'b10010, 1);
        issue_k(0, 4'd12,  16'h3C, 16'h55, 1'b1, 1'b1, 16'hFF, 5'b00001, 1);
        issue_k(1, OP_ADD, 16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0000, 5'b11010, 4);
        drain(0);
        drain(1);

        // Back-pressure: result held three cycles, then release with a new request in the same cycle.
        hold8 = 1;
        issue_m(0, OP_ADD, 16'h37, 16'h29, 1'b0, 1'b1, first);
        for (int k = 0; k < 50 && !out_valid8; k++) begin
            @(negedge clk);
            #3;
        end
        chk("bp_out_valid_seen", 32'(out_valid8), 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #3;
            chk("bp_in_ready_low", 32'(in_ready8), 0);
            chk("bp_out_valid_held", 32'(out_valid8), 1);
        end
        hold8 = 0;
        issue_m(0, OP_OR, 16'h0F, 16'hA0, 1'b0, 1'b0, first);
        chk("bp_no_bubble", 32'(first), 1);
        drain(0);

        // Reset in the middle of a 16-bit add.
        issue_m(1, OP_ADD, 16'h1234, 16'h1111, 1'b0, 1'b0, first);
        @(posedge clk);
        @(negedge clk);
        rst16_n = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("midrun_rst_out_valid", 32'(out_valid16), 0);
        chk("midrun_rst_in_ready", 32'(in_ready16), 1);
        chk("midrun_rst_data", 32'(d16), 0);
        chk("midrun_rst_flags", 32'({c16, h16, v16, z16, n16}), 0);
        if (q16.size() > 0) void'(q16.pop_back());
        rst16_n = 1;

        // Random traffic with random back-pressure on both widths.
        rnd8 = 1; rnd16 = 1;
        for (int i = 0; i < 120; i++) begin
            w   = int'($urandom_range(0, 1));
            rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            if (w == 0) begin ra[15:8] = 8'h00; rb[15:8] = 8'h00; end
            issue_m(w, rop, ra, rb, 1'($urandom), 1'($urandom), first);
        end
        drain(0);
        drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
